ntsc_fvh_gen: RTL and testbench

- Transmit-side counterpart of the camera-input path.
- Generates an interlaced video stream (fvh[2:0], dv, 8-bit luma pixel) with the same conventions the capture/sobel input logic consumes.
- Fetches each active pixel from a frame-buffer read port.
- Used to drive downstream video logic and as a deterministic source for closed-loop tests of the capture chain.

---
 rtl/ntsc_pkg.sv | 29 ++
 rtl/ntsc_fvh_gen_timing.sv | 101 ++++++++++
 rtl/ntsc_fvh_gen.sv | 117 +++++++++++
 tb/tb_ntsc_fvh_gen.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ntsc_pkg.sv
// rtl/ntsc_pkg.sv - shared constants, state types and row helper for the fvh generator
package ntsc_pkg;

    localparam int COORD_W = 10;

    localparam int FVH_F = 2;
    localparam int FVH_V = 1;
    localparam int FVH_H = 0;

    localparam int ACT_W_DEF     = 720;
    localparam int HBLANK_DEF    = 138;
    localparam int ACT_LINES_DEF = 243;
    localparam int VBLANK_DEF    = 20;
    localparam int DV_DIV_DEF    = 2;

    typedef enum logic {H_ACTIVE = 1'b0, H_BLANK  = 1'b1} h_state_e;
    typedef enum logic {V_BLANK  = 1'b0, V_ACTIVE = 1'b1} v_state_e;
    typedef enum logic {RUN_STOP = 1'b0, RUN_GO   = 1'b1} run_state_e;

    // Interlaced frame row: even field on even rows, odd field on odd rows; wraps silently
    function automatic logic [COORD_W-1:0] frame_row(
        input logic [COORD_W-1:0] line,
        input logic [COORD_W-1:0] vblank,
        input logic               field
    );
        return ((line - vblank) << 1) | {{(COORD_W-1){1'b0}}, field};
    endfunction

endpackage

// File: rtl/ntsc_fvh_gen_timing.sv
// rtl/ntsc_fvh_gen_timing.sv - div/pix/line/field counters with run/stop gating
module ntsc_timing_cnt
    import ntsc_pkg::*;
#(
    parameter int ACT_W     = ACT_W_DEF,
    parameter int HBLANK    = HBLANK_DEF,
    parameter int ACT_LINES = ACT_LINES_DEF,
    parameter int VBLANK    = VBLANK_DEF,
    parameter int DV_DIV    = DV_DIV_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    output logic               field_o,
    output logic               div_zero_o,
    output logic [COORD_W-1:0] pix_o,
    output logic [COORD_W-1:0] line_o,
    output h_state_e           h_state_o,
    output v_state_e           v_state_o
);

    localparam int DIV_W = 2;
    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(DV_DIV - 1);
    localparam logic [COORD_W-1:0] PIX_LAST  = COORD_W'(ACT_W + HBLANK - 1);
    localparam logic [COORD_W-1:0] LINE_LAST = COORD_W'(VBLANK + ACT_LINES - 1);
    localparam logic [COORD_W-1:0] ACT_W_C   = COORD_W'(ACT_W);
    localparam logic [COORD_W-1:0] VBLANK_C  = COORD_W'(VBLANK);

    run_state_e         run_q, run_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [COORD_W-1:0] pix_q, pix_d;
    logic [COORD_W-1:0] line_q, line_d;
    logic               field_q, field_d;
    logic               adv, div_wrap, pix_wrap, line_wrap;

    assign div_wrap  = (div_q == DIV_LAST);
    assign pix_wrap  = div_wrap && (pix_q == PIX_LAST);
    assign line_wrap = pix_wrap && (line_q == LINE_LAST);

    // Run control: en matters only while stopped or on the last clock of a field
    always_comb begin
        run_d = run_q;
        adv   = 1'b0;
        if (run_q == RUN_STOP) begin
            if (en_i) begin
                adv   = 1'b1;
                run_d = RUN_GO;
            end
        end else begin
            adv = 1'b1;
            if (line_wrap && !en_i) begin
                run_d = RUN_STOP;
            end
        end
    end

    // Cascaded counter advance; a stop at the field wrap leaves everything at field start
    always_comb begin
        div_d   = div_q;
        pix_d   = pix_q;
        line_d  = line_q;
        field_d = field_q;
        if (adv) begin
            div_d = div_wrap ? '0 : div_q + 1'b1;
            if (div_wrap) begin
                pix_d = (pix_q == PIX_LAST) ? '0 : pix_q + 1'b1;
            end
            if (pix_wrap) begin
                line_d = (line_q == LINE_LAST) ? '0 : line_q + 1'b1;
            end
            if (line_wrap) begin
                field_d = ~field_q;
            end
        end
    end

    // State registers, cleared straight to the stopped field-0 origin
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q   <= RUN_STOP;
            div_q   <= '0;
            pix_q   <= '0;
            line_q  <= '0;
            field_q <= 1'b0;
        end else begin
            run_q   <= run_d;
            div_q   <= div_d;
            pix_q   <= pix_d;
            line_q  <= line_d;
            field_q <= field_d;
        end
    end

    assign field_o    = field_q;
    assign div_zero_o = (div_q == '0);
    assign pix_o      = pix_q;
    assign line_o     = line_q;
    assign h_state_o  = (pix_q < ACT_W_C) ? H_ACTIVE : H_BLANK;
    assign v_state_o  = (line_q < VBLANK_C) ? V_BLANK : V_ACTIVE;

endmodule

// File: rtl/ntsc_fvh_gen.sv
// rtl/ntsc_fvh_gen.sv - interlaced fvh/dv/pixel stream source fed from a frame-buffer read port
module ntsc_fvh_gen
    import ntsc_pkg::*;
#(
    parameter int ACT_W     = ACT_W_DEF,
    parameter int HBLANK    = HBLANK_DEF,
    parameter int ACT_LINES = ACT_LINES_DEF,
    parameter int VBLANK    = VBLANK_DEF,
    parameter int DV_DIV    = DV_DIV_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    output logic               rd_en_o,
    output logic [COORD_W-1:0] rd_col_o,
    output logic [COORD_W-1:0] rd_row_o,
    input  logic [7:0]         rd_data_i,
    output logic [2:0]         fvh_o,
    output logic               dv_o,
    output logic [7:0]         pixel_o,
    output logic               sof_o
);

    localparam logic [COORD_W-1:0] ACT_W_C  = COORD_W'(ACT_W);
    localparam logic [COORD_W-1:0] VBLANK_C = COORD_W'(VBLANK);

    logic               field, div_zero;
    logic [COORD_W-1:0] pix, line;
    h_state_e           h_state;
    v_state_e           v_state;

    ntsc_timing_cnt #(
        .ACT_W     (ACT_W),
        .HBLANK    (HBLANK),
        .ACT_LINES (ACT_LINES),
        .VBLANK    (VBLANK),
        .DV_DIV    (DV_DIV)
    ) u_timing (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .en_i       (en_i),
        .field_o    (field),
        .div_zero_o (div_zero),
        .pix_o      (pix),
        .line_o     (line),
        .h_state_o  (h_state),
        .v_state_o  (v_state)
    );

    logic               strobe_d;
    logic [2:0]         fvh_d;
    logic [COORD_W-1:0] rd_row_d;
    logic               sof_d;

    logic               rd_en_q;
    logic [COORD_W-1:0] rd_col_q, rd_row_q;
    logic [2:0]         fvh1_q, fvh2_q;
    logic               sof1_q, sof2_q;
    logic               dv_q;
    logic [7:0]         pixel_q;

    assign strobe_d = div_zero && (h_state == H_ACTIVE) && (v_state == V_ACTIVE);
    assign rd_row_d = frame_row(line, VBLANK_C, field);
    // Field bit leaving 1 for 0 between consecutive stage-0 cycles marks start of frame
    assign sof_d    = !fvh_d[FVH_F] && fvh1_q[FVH_F];

    // Stage-0 sync word: field level, vblank level, single-clock hsync on every line
    always_comb begin
        fvh_d        = '0;
        fvh_d[FVH_F] = field;
        fvh_d[FVH_V] = (v_state == V_BLANK);
        fvh_d[FVH_H] = div_zero && (pix == ACT_W_C);
    end

    // Stage 1: issue the frame-buffer read and carry sync alongside it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_en_q  <= 1'b0;
            rd_col_q <= '0;
            rd_row_q <= '0;
            fvh1_q   <= '0;
            sof1_q   <= 1'b0;
        end else begin
            rd_en_q  <= strobe_d;
            rd_col_q <= pix;
            rd_row_q <= rd_row_d;
            fvh1_q   <= fvh_d;
            sof1_q   <= sof_d;
        end
    end

    // Stage 2: capture returned pixel so dv, pixel, fvh and sof leave together
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dv_q    <= 1'b0;
            pixel_q <= '0;
            fvh2_q  <= '0;
            sof2_q  <= 1'b0;
        end else begin
            dv_q   <= rd_en_q;
            fvh2_q <= fvh1_q;
            sof2_q <= sof1_q;
            if (rd_en_q) begin
                pixel_q <= rd_data_i;
            end
        end
    end

    assign rd_en_o  = rd_en_q;
    assign rd_col_o = rd_col_q;
    assign rd_row_o = rd_row_q;
    assign fvh_o    = fvh2_q;
    assign dv_o     = dv_q;
    assign pixel_o  = pixel_q;
    assign sof_o    = sof2_q;

endmodule

// File: tb/tb_ntsc_fvh_gen.sv
// tb/tb_ntsc_fvh_gen.sv - self-checking bench for ntsc_fvh_gen at DV_DIV=2 and DV_DIV=3
module tb_ntsc_fvh_gen;

    localparam int AW = 8;
    localparam int HB = 4;
    localparam int AL = 3;
    localparam int VB = 2;
    localparam int PT = AW + HB;
    localparam int LT = VB + AL;

    typedef struct packed {
        logic       strobe;
        logic [2:0] fvh;
        logic [9:0] col;
        logic [9:0] row;
    } ent_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic       rd_en   [2];
    logic [9:0] rd_col  [2];
    logic [9:0] rd_row  [2];
    logic [7:0] rd_data [2];
    logic [2:0] fvh     [2];
    logic       dv      [2];
    logic [7:0] pixel   [2];
    logic       sof     [2];

    int   total = 0;
    int   bad   = 0;
    int   m_t    [2];
    bit   m_stop [2];
    ent_t h0 [2];
    ent_t h1 [2];
    ent_t h2 [2];
    int   cyc     = 0;
    bit   measure = 1'b0;
    int   last_hs = -1;
    int   last_dv = -1;
    bit   found;

    always #5 clk = ~clk;

    assign rd_data[0] = 8'(rd_row[0] * 10'd16 + rd_col[0]);
    assign rd_data[1] = 8'(rd_row[1] * 10'd16 + rd_col[1]);

    ntsc_fvh_gen #(.ACT_W(AW), .HBLANK(HB), .ACT_LINES(AL), .VBLANK(VB), .DV_DIV(2)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en),
        .rd_en_o(rd_en[0]), .rd_col_o(rd_col[0]), .rd_row_o(rd_row[0]), .rd_data_i(rd_data[0]),
        .fvh_o(fvh[0]), .dv_o(dv[0]), .pixel_o(pixel[0]), .sof_o(sof[0])
    );

    ntsc_fvh_gen #(.ACT_W(AW), .HBLANK(HB), .ACT_LINES(AL), .VBLANK(VB), .DV_DIV(3)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en),
        .rd_en_o(rd_en[1]), .rd_col_o(rd_col[1]), .rd_row_o(rd_row[1]), .rd_data_i(rd_data[1]),
        .fvh_o(fvh[1]), .dv_o(dv[1]), .pixel_o(pixel[1]), .sof_o(sof[1])
    );

    // Expected stage-0 view of running clock t, from plain division of elapsed clocks
    function automatic ent_t model_ent(input int t, input int dd);
        int   d, p, l, f;
        ent_t e;
        d = t % dd;
        p = (t / dd) % PT;
        l = (t / (dd * PT)) % LT;
        f = (t / (dd * PT * LT)) % 2;
        e.strobe = (d == 0) && (p < AW) && (l >= VB);
        e.fvh    = {f[0], (l < VB), (d == 0) && (p == AW)};
        e.col    = 10'(p);
        e.row    = 10'(2 * (l - VB) + f);
        return e;
    endfunction

    task automatic chk(input string tag, input int inst, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s dut%0d got=%0h exp=%0h cyc=%0d", tag, inst + 2, got, exp, cyc);
        end
    endtask

    task automatic step();
        for (int i = 0; i < 2; i++) begin
            int dd;
            dd = (i == 0) ? 2 : 3;
            h2[i] = h1[i];
            h1[i] = h0[i];
            if (!rst_n) begin
                h0[i] = '0; h1[i] = '0; h2[i] = '0;
                m_t[i] = 0; m_stop[i] = 1'b1;
            end else begin
                h0[i] = model_ent(m_t[i], dd);
                if (m_stop[i]) begin
                    if (en) begin
                        m_stop[i] = 1'b0;
                        m_t[i]++;
                    end
                end else begin
                    m_t[i]++;
                    if ((m_t[i] % (dd * PT * LT) == 0) && !en) m_stop[i] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            chk("rd_en", i, rd_en[i], h0[i].strobe);
            if (h0[i].strobe) begin
                chk("rd_col", i, rd_col[i], h0[i].col);
                chk("rd_row", i, rd_row[i], h0[i].row);
            end
            chk("fvh", i, fvh[i], h1[i].fvh);
            chk("dv", i, dv[i], h1[i].strobe);
            if (h1[i].strobe) chk("pixel", i, pixel[i], 8'(h1[i].row * 16 + h1[i].col));
            chk("sof", i, sof[i], !h1[i].fvh[2] && h2[i].fvh[2]);
            if (!rst_n) chk("pixel_rst", i, pixel[i], 0);
        end
        if (measure) begin
            if (fvh[1][0]) begin
                if (last_hs >= 0) chk("hs_period", 1, cyc - last_hs, 36);
                last_hs = cyc;
            end
            if (dv[1]) begin
                if (last_dv >= 0 && (cyc - last_dv) < 12) chk("dv_space", 1, cyc - last_dv, 3);
                last_dv = cyc;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        repeat (6) step();
        chk("stopped_fvh", 0, fvh[0], 3'b010);
        chk("stopped_dv", 0, dv[0], 0);

        en = 1'b1;
        measure = 1'b1;
        repeat (480) step();
        measure = 1'b0;

        repeat (30) step();
        en = 1'b0;
        repeat (2 * PT * LT - 30 + 2) step();
        for (int k = 0; k < 50; k++) begin
            step();
            chk("hold_fvh", 0, fvh[0], 3'b110);
            chk("hold_dv", 0, dv[0], 0);
        end
        en = 1'b1;
        repeat (300) step();

        for (int k = 0; k < 1500; k++) begin
            en = ($urandom_range(0, 3) != 0);
            step();
        end

        en = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            if (!m_stop[0] && ((m_t[0] / 2) % PT) == 3 && ((m_t[0] / (2 * PT)) % LT) >= VB) found = 1'b1;
            else step();
        end
        chk("wait_pix3", 0, found, 1);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_rd_en", i, rd_en[i], 0);
            chk("rst_fvh", i, fvh[i], 0);
            chk("rst_dv", i, dv[i], 0);
            chk("rst_pixel", i, pixel[i], 0);
            chk("rst_sof", i, sof[i], 0);
        end
        repeat (2) step();
        rst_n = 1'b1;
        for (int k = 0; k < 2 * PT * VB; k++) begin
            step();
            chk("post_rst_no_dv", 0, dv[0], 0);
        end
        repeat (200) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
